dac_tx: RTL and testbench
=========================

# dac_tx

Playback-side converter driver for the voice path: accepts 12-bit unsigned audio samples from the decoder over a valid/ready stream and buffers them in a small FIFO. It paces them out to a parallel 12-bit DAC at clk_in/DIV, generating the DAC clock. It removes the capture-side DC offset with saturation and applies the board's bit-reversed pin mapping. It sits at the analog output boundary, mirroring the ADC capture block on the input side.

## Interface
- DATA_W, 12, sample width (fixed at 12 for this board).
- FIFO_DEPTH, 16, FIFO entries, power of two, ≥4.
- DIV, 4, clk_in cycles per output sample, even, ≥2.
- CH_OFFSET, 27, signed offset subtracted from each sample before output.
- BIT_REVERSE, 1, 1 = DA_data[i] carries sample bit [DATA_W-1-i].
- MIDSCALE, 12'h800, idle/reset output code (before reversal).
- Clocking/reset: reset rst_n, synchronous, active-low; clock clk_in.
- clk_in  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_data  in  12  input sample, unsigned.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO not full.
- DA_clk  out  1  DAC clock, registered, period DIV cycles.
- DA_data  out  12  DAC code, registered.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underflow  out  1  one-cycle pulse on an output tick with FIFO empty in RUN.

## Operation
- Push on s_valid && s_ready. s_ready = !full (combinational from registered pointers). Pushes while rst_n=0 are ignored.
- Phase counter cnt counts 0..DIV-1 and wraps. Tick = (cnt == DIV-1).
- States:
  - PRIME: output holds at the current DA_data value, no pops. Transition to RUN when level ≥ FIFO_DEPTH/2, evaluated every cycle.
  - RUN: on each tick, if not empty, pop and load DA_data. If empty, hold DA_data, pulse underflow, go to PRIME.
- Data path: d = {1'b0,sample} − CH_OFFSET in 14-bit signed arithmetic, saturated to [0, 4095]. Apply bit reversal if BIT_REVERSE, then register into DA_data.
- Empty test on a tick uses the registered empty flag. A push in the same cycle as an empty tick does not prevent the underrun.
- Simultaneous push and pop (not full, not empty): level unchanged.

## Timing
- Reset values: cnt=0, DA_clk=0, DA_data=rev(MIDSCALE) (12'h001 with defaults), state PRIME, FIFO empty, level=0, underflow=0, s_ready=1.
- DA_clk = 0 for cnt ∈ [0, DIV/2−1] and 1 for cnt ∈ [DIV/2, DIV−1], driven from a register (no glitches).
- DA_data changes only at the edge where cnt wraps DIV−1→0, coincident with DA_clk falling. It is stable for DIV/2 cycles before the DAC latches on DA_clk rising.
- Latency: a sample pushed into an empty FIFO in RUN cannot appear. Priming requires FIFO_DEPTH/2 entries; the first output appears at the first tick after the threshold is reached, and DA_data is valid on the following cycle.
- level updates one cycle after push/pop. underflow is asserted for exactly the tick-edge cycle.
- Reset mid-operation: FIFO flushed, output returns to midscale on the next edge, phase restarts at cnt=0.

## Structure
- Package dac_tx_pkg:
  - state enum {PRIME, RUN}.
  - function bit_rev12.
  - function sat_u12 (14-bit signed → 12-bit unsigned).
- One sub-module: sync_fifo (parameterised width/depth, registered full/empty/level, wrap-bit pointers).
- The top level holds the phase counter, the FSM, and the output register.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with s_valid=1 → DA_data=12'h001, DA_clk=0, level=0, s_ready=1, no pushes accepted.
- Priming: push 8 samples 12'h81B each back-to-back → state RUN after level=8. DA_data = rev(12'h800) = 12'h001 at the next wrap, then one sample per 4 cycles; DA_clk period 4, 50% duty.
- Saturation: push 12'h010 and 12'hFFF (with 6 fillers) → outputs rev(12'h000)=12'h000 and rev(12'hFE4)=12'h27F.
- Full: push 20 samples with no pops (PRIME held by forcing DIV phase) → s_ready=0 at level=16, pushes 17–20 rejected, level stays 16.
- Underrun: prime 8 samples then stop input → exactly 8 distinct outputs, then an underflow pulse at the 9th tick. DA_data holds the last value and the state returns to PRIME; refill of 8 restarts output.
- Reset mid-stream in RUN → FIFO empties, DA_data=12'h001 next cycle, cnt restarts at 0.

Source files
------------

// File: rtl/dac_tx_pkg.sv
// Shared types and helpers for the playback DAC driver.
package dac_tx_pkg;

  // Output sequencer states: PRIME waits for a half-full FIFO, RUN paces samples out.
  typedef enum logic {
    PRIME,
    RUN
  } state_e;

  localparam int SAMPLE_W = 12;

  // Board pin mapping: DAC pin i carries sample bit (SAMPLE_W-1-i).
  function automatic logic [SAMPLE_W-1:0] bit_rev12(input logic [SAMPLE_W-1:0] v);
    logic [SAMPLE_W-1:0] r;
    r = '0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      r[i] = v[SAMPLE_W-1-i];
    end
    return r;
  endfunction

  // Clamp a 14-bit signed intermediate to the unsigned 12-bit DAC range.
  function automatic logic [SAMPLE_W-1:0] sat_u12(input logic signed [13:0] v);
    if (v < 14'sd0) begin
      return '0;
    end else if (v > 14'sd4095) begin
      return 12'hFFF;
    end else begin
      return v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dac_tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered full/empty/level.
// Read data is presented from the head entry without a pop (fall-through).
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok  = push_i && !full_q;
  assign pop_ok   = pop_i && !empty_q;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  // The extra pointer bit makes the difference a true occupancy count, 0..DEPTH.
  assign level_d  = wr_ptr_d - rd_ptr_d;

  // Pointer and status registers; flags are derived from next-state occupancy.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == (AW+1)'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_in) begin
    // NOTE: the array has no reset; the pointers alone define which entries are live.
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/dac_tx.sv
// Playback DAC driver: buffers decoder samples, removes the capture DC offset,
// and paces codes out to a parallel DAC at clk_in/DIV with a generated DAC clock.
module dac_tx
  import dac_tx_pkg::*;
#(
  parameter int              DATA_W      = 12,
  parameter int              FIFO_DEPTH  = 16,
  parameter int              DIV         = 4,
  parameter int              CH_OFFSET   = 27,
  parameter int              BIT_REVERSE = 1,
  parameter logic [11:0]     MIDSCALE    = 12'h800
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          DA_clk,
  output logic [DATA_W-1:0]             DA_data,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underflow
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [11:0] MID_PIN = (BIT_REVERSE != 0) ? bit_rev12(MIDSCALE) : MIDSCALE;

  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [LVL_W-1:0]  fifo_level;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic              da_clk_q, underflow_q;
  logic [11:0]       da_data_q;
  logic [11:0]       pin_code;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tick     = (cnt_q == CNT_W'(DIV - 1));
  assign cnt_d    = tick ? '0 : cnt_q + 1'b1;
  // The empty test uses the registered flag, so a same-cycle push cannot rescue a tick.
  assign fifo_pop = (state_q == RUN) && tick && !fifo_empty;

  // Offset removal, saturation and pin mapping for the FIFO head sample.
  always_comb begin
    logic signed [13:0] diff;
    logic [11:0]        sat_code;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    diff     = '0;
    sat_code = '0;
    pin_code = '0;
    diff     = $signed({2'b00, fifo_data}) - $signed(14'(CH_OFFSET));
    sat_code = sat_u12(diff);
    pin_code = (BIT_REVERSE != 0) ? bit_rev12(sat_code) : sat_code;
  end

  // Phase counter, DAC clock, and the PRIME/RUN sequencer with registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= PRIME;
      cnt_q       <= '0;
      da_clk_q    <= 1'b0;
      da_data_q   <= MID_PIN;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      // Clock high for the second half of the phase; code changes as it falls.
      da_clk_q    <= (cnt_d >= CNT_W'(DIV / 2));
      underflow_q <= 1'b0;
      case (state_q)
        PRIME: begin
          if (fifo_level >= LVL_W'(FIFO_DEPTH / 2)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (fifo_empty) begin
              underflow_q <= 1'b1;
              state_q     <= PRIME;
            end else begin
              da_data_q <= pin_code;
            end
          end
        end
        default: state_q <= PRIME;
      endcase
    end
  end

  assign s_ready   = !fifo_full;
  assign DA_clk    = da_clk_q;
  assign DA_data   = da_data_q;
  assign level     = fifo_level;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_dac_tx.sv
// Directed bench for dac_tx: reset, priming, saturation, pacing, underrun,
// refill, mid-stream reset, and FIFO-full behaviour (on a slow-divider instance).
module tb_dac_tx;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        da_clk;
  logic [11:0] da_data;
  logic [4:0]  level;
  logic        underflow;

  logic [11:0] f_data;
  logic        f_valid;
  logic        f_ready;
  logic        f_da_clk;
  logic [11:0] f_da_data;
  logic [4:0]  f_level;
  logic        f_underflow;

  int checks = 0;
  int errors = 0;

  // Input samples and their hand-computed DAC pin codes (x - 27, clamp, reverse).
  logic [11:0] vec_in  [8];
  logic [11:0] vec_out [8];

  always #5 clk_in = ~clk_in;

  dac_tx u_dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .DA_clk    (da_clk),
    .DA_data   (da_data),
    .level     (level),
    .underflow (underflow)
  );

  // Slow divider so the FIFO can fill before the first pop.
  dac_tx #(.DIV(64)) u_dut_full (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s_data    (f_data),
    .s_valid   (f_valid),
    .s_ready   (f_ready),
    .DA_clk    (f_da_clk),
    .DA_data   (f_da_data),
    .level     (f_level),
    .underflow (f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Run edges c_from..c_to (numbered from the last reset edge) after 8 entries
  // were loaded; the first pop happens at edge p, earlier edges hold 'hold'.
  task automatic play(input int c_from, input int c_to, input int p, input logic [11:0] hold);
    logic [11:0] exp_d;
    int          exp_l;
    int          k;
    for (int c = c_from; c <= c_to; c++) begin
      step();
      if (c < p) begin
        exp_d = hold;
        exp_l = 8;
      end else begin
        k     = (c - p) / 4;
        exp_d = (k < 8) ? vec_out[k] : vec_out[7];
        exp_l = (k < 8) ? 7 - k : 0;
      end
      check($sformatf("da_data@%0d", c), 32'(da_data), 32'(exp_d));
      check($sformatf("da_clk@%0d", c), 32'(da_clk), 32'((c % 4) >= 2));
      check($sformatf("level@%0d", c), 32'(level), 32'(exp_l));
      check($sformatf("underflow@%0d", c), 32'(underflow), 32'(c == p + 32));
      check($sformatf("s_ready@%0d", c), 32'(s_ready), 32'd1);
    end
  endtask

  initial begin
    vec_in[0] = 12'h81B; vec_out[0] = 12'h001;  // 0x800 midscale
    vec_in[1] = 12'h010; vec_out[1] = 12'h000;  // below offset, clamps to 0
    vec_in[2] = 12'hFFF; vec_out[2] = 12'h27F;  // 0xFE4
    vec_in[3] = 12'h01C; vec_out[3] = 12'h800;  // 0x001, just above the clamp
    vec_in[4] = 12'h11B; vec_out[4] = 12'h008;  // 0x100
    vec_in[5] = 12'h02B; vec_out[5] = 12'h080;  // 0x010
    vec_in[6] = 12'h41B; vec_out[6] = 12'h002;  // 0x400
    vec_in[7] = 12'h0A6; vec_out[7] = 12'hD10;  // 0x08B

    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 12'h123;
    f_valid = 1'b0;
    f_data  = '0;

    // Reset with pushes offered: nothing may be accepted.
    repeat (3) step();
    check("rst_da_data", 32'(da_data), 32'h001);
    check("rst_da_clk", 32'(da_clk), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);

    // Prime with 8 samples on edges 1..8.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = vec_in[i];
      step();
      check($sformatf("prime_level%0d", i), 32'(level), 32'(i + 1));
    end
    s_valid = 1'b0;

    // RUN from edge 9; pops at 12,16..40, underrun at 44.
    play(9, 45, 12, 12'h001);

    // Refill on edges 46..53; RUN from 54, first pop at 56.
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = vec_in[i];
      step();
    end
    s_valid = 1'b0;
    play(54, 62, 56, 12'hD10);

    // Reset in the middle of RUN.
    rst_n = 1'b0;
    step();
    check("mid_rst_da_data", 32'(da_data), 32'h001);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_da_clk", 32'(da_clk), 32'd0);
    check("mid_rst_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    step();
    check("restart_clk_cnt1", 32'(da_clk), 32'd0);
    step();
    check("restart_clk_cnt2", 32'(da_clk), 32'd1);
    check("restart_level", 32'(level), 32'd0);

    // Fill the slow instance: pushes 17..20 must be rejected.
    f_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      f_data = 12'(i);
      step();
      check($sformatf("full_level%0d", i), 32'(f_level), 32'((i + 1 < 16) ? i + 1 : 16));
      check($sformatf("full_ready%0d", i), 32'(f_ready), 32'(i + 1 < 16));
    end
    f_valid = 1'b0;
    step();
    check("full_level_hold", 32'(f_level), 32'd16);
    check("full_da_data", 32'(f_da_data), 32'h001);
    check("full_underflow", 32'(f_underflow), 32'd0);

    // Main instance idled in PRIME with an empty FIFO: no underflow, code held.
    check("idle_underflow", 32'(underflow), 32'd0);
    check("idle_da_data", 32'(da_data), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
